uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Serial program loader. Acts as initiator on the uart_fifo register interface, the same bus the CPU uses. It pulls a framed image from the host over UART and writes it word by word into CPU program memory.
- Holds the CPU in reset until a frame passes its checksum, then returns ACK or NAK to the host through the uart_fifo TX path.
- Sits in the top level between uart_fifo, program RAM and cpu_top. It is muxed onto the uart bus while cpu_rst is high.

Parameters:
- DATA_W, 8, UART byte width; equals UartDataWidth.
- ADDR_W, 12, program-memory word-address width; capacity is 2^ADDR_W words.
- TIMEOUT, 1_000_000, idle clk cycles allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_in  in  1  synchronous, active-low reset.
- uart_rd  out  1  one-cycle read strobe; pops the RX byte.
- uart_wr  out  1  one-cycle write strobe; pushes uart_din into TX.
- uart_addr  out  2  register select: 0 = data, 1 = status.
- uart_din  out  DATA_W  TX byte.
- uart_dout  in  DATA_W  RX byte; valid the cycle after uart_rd.
- uart_dout1  in  DATA_W  status, combinational: bit0 = rx_empty, bit1 = tx_full.
- mem_we  out  1  one-cycle program-RAM write enable.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  word data.
- cpu_rst  out  1  high keeps the CPU in reset.
- boot_done  out  1  sticky; set on first ACK.

Behaviour:
- Reset (rst_in = 0 at a clk edge):
  - Outputs: uart_rd/uart_wr/mem_we = 0, uart_addr = 1, uart_din = 0, mem_addr = 0, mem_wdata = 0, cpu_rst = 1, boot_done = 0.
  - State = HUNT.
  - Reset mid-frame discards everything and re-asserts cpu_rst.
- Frame format, bytes:
  - 0xA5 magic.
  - LEN_L, LEN_H: word count N, little-endian.
  - N × 4 data bytes, little-endian per word.
  - CK: XOR of LEN_L, LEN_H and all data bytes.
- Byte fetch sub-sequence, used by every receive state:
  - POLL: uart_addr = 1; wait until uart_dout1[0] = 0.
  - Next cycle: uart_addr = 0, uart_rd = 1 for exactly one cycle.
  - Following cycle: capture uart_dout.
  - Minimum 3 cycles per byte.
  - uart_rd is never asserted while rx_empty = 1.
- States:
  - HUNT: fetch bytes and discard any that are not 0xA5. On 0xA5: cpu_rst = 1, clear the checksum and the byte/word counters, go to LEN0.
  - LEN0 / LEN1: fetch bytes, XOR each into the checksum. If N > 2^ADDR_W, respond NAK and go back to HUNT. If N = 0, go to CKSUM.
  - DATA: fetch 4 bytes into the word, low byte first, XOR each into the checksum, then go to WRITE.
  - WRITE: one cycle with mem_we = 1, mem_addr = word index (first word at 0), mem_wdata = assembled word. Increment the index. Go to CKSUM when index = N, otherwise back to DATA.
  - CKSUM: fetch CK. Equal to the running XOR selects ACK (0x06); unequal selects NAK (0x15).
  - RESP: poll status until tx_full = 0, then one cycle with uart_addr = 0, uart_wr = 1, uart_din = response. On ACK: cpu_rst = 0 and boot_done = 1 on the following cycle. Then go to HUNT.
- After ACK:
  - HUNT keeps listening; cpu_rst stays low until a new 0xA5 arrives. This allows reload.
  - The uart bus is owned by the CPU only while cpu_rst = 0.
  - Known limitation: a 0xA5 byte sent to the CPU's console is also seen by the loader.
- Timeout:
  - The idle counter runs in LEN0..CKSUM and clears on each captured byte.
  - Reaching TIMEOUT sends NAK and returns to HUNT.
  - Words already written stay in RAM; cpu_rst stays 1.
- NAK never clears cpu_rst or boot_done.
- Writes already done in a NAKed frame are not rolled back.
- mem_we fires exactly N times per accepted frame.
- The word index wraps at 2^ADDR_W only when N = 2^ADDR_W exactly; there is no overrun.

Test Plan:
- Frame A5 02 00 | 78 56 34 12 | EF BE AD DE | CK = 0x02^…^0xDE -> two writes (addr 0: 0x12345678, addr 1: 0xDEADBEEF), one TX of 0x06, cpu_rst falls, boot_done = 1.
- Same frame with CK bit0 flipped -> both writes occur, TX 0x15, cpu_rst stays 1, boot_done stays 0.
- Garbage 00 FF 5A before A5 01 00 11 22 33 44 CK -> garbage ignored, single write of 0x44332211 to addr 0, ACK.
- A5 00 00 CK = 0x00 -> no mem_we, ACK; A5 01 10 (N = 4097 > 4096) -> immediate NAK, no write.
- Frame stalls after 2 data bytes for TIMEOUT cycles (TIMEOUT = 100 in the bench) -> NAK; a following valid frame is accepted.
- rx_empty toggling slowly and tx_full held high for 50 cycles during RESP -> uart_rd never asserted while empty; uart_wr is issued on the first cycle after tx_full drops. rst_in pulsed low mid-DATA -> all outputs return to reset values; no spurious mem_we.

Source files
------------

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: uart_fifo register bus plus the program-RAM write port, driven by the loader.
interface uart_boot_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic              uart_rd;
  logic              uart_wr;
  logic [1:0]        uart_addr;
  logic [DATA_W-1:0] uart_din;
  logic [DATA_W-1:0] uart_dout;
  logic [DATA_W-1:0] uart_dout1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master (
    output uart_rd, uart_wr, uart_addr, uart_din, mem_we, mem_addr, mem_wdata,
    input  uart_dout, uart_dout1
  );
  modport slave (
    input  uart_rd, uart_wr, uart_addr, uart_din, mem_we, mem_addr, mem_wdata,
    output uart_dout, uart_dout1
  );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: pulls a framed image over the uart_fifo bus into program RAM and releases the CPU on a good checksum.
module uart_boot_loader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_in,
  uart_boot_loader_if.master bus,
  output logic               cpu_rst,
  output logic               boot_done
);
  localparam logic [2:0] HUNT = 3'd0, LEN0 = 3'd1, LEN1 = 3'd2, DATA = 3'd3, WRITE = 3'd4, CKSUM = 3'd5, RESP = 3'd6;
  localparam logic [7:0] MAGIC = 8'hA5, ACK = 8'h06, NAK = 8'h15;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;
  logic [2:0]    state;
  logic [1:0]    ph, bc;
  logic [7:0]    ck, resp, b;
  logic [15:0]   n;
  logic [16:0]   idx;
  logic [23:0]   word;
  logic [IW-1:0] idle;
  logic          fetch, cap, timed_out, unused_status;
  assign b = bus.uart_dout[7:0];
  assign unused_status = ^bus.uart_dout1[DATA_W-1:2];
  // ph walks poll -> read strobe -> capture for every byte fetched
  assign fetch = state != WRITE && state != RESP;
  assign cap = fetch && ph == 2'd2;
  assign timed_out = state != HUNT && fetch && !cap && idle == IDLE_MAX;
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state <= HUNT;
      ph <= '0;
      bc <= '0;
      ck <= '0;
      resp <= '0;
      n <= '0;
      idx <= '0;
      word <= '0;
      idle <= '0;
      bus.uart_rd <= 1'b0;
      bus.uart_wr <= 1'b0;
      bus.uart_addr <= 2'd1;
      bus.uart_din <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      cpu_rst <= 1'b1;
      boot_done <= 1'b0;
    end else begin
      bus.uart_rd <= 1'b0;
      bus.uart_wr <= 1'b0;
      bus.mem_we <= 1'b0;
      idle <= (state == HUNT || state == RESP || cap) ? '0 : idle + 1'b1;
      if (fetch) begin
        ph <= ph == 2'd0 ? {1'b0, !bus.uart_dout1[0]} : ph == 2'd1 ? 2'd2 : 2'd0;
        bus.uart_rd <= ph == 2'd0 && !bus.uart_dout1[0];
        bus.uart_addr <= (ph == 2'd2 || (ph == 2'd0 && bus.uart_dout1[0])) ? 2'd1 : 2'd0;
      end
      if (cap)
        case (state)
          HUNT: if (b == MAGIC) begin
            cpu_rst <= 1'b1;
            ck <= '0;
            idx <= '0;
            bc <= '0;
            state <= LEN0;
          end
          LEN0: begin
            n[7:0] <= b;
            ck <= ck ^ b;
            state <= LEN1;
          end
          LEN1: begin
            n[15:8] <= b;
            ck <= ck ^ b;
            resp <= NAK;
            state <= {1'b0, b, n[7:0]} > MAX_N ? RESP : {b, n[7:0]} == 16'd0 ? CKSUM : DATA;
          end
          DATA: begin
            ck <= ck ^ b;
            bc <= bc + 1'b1;
            word <= {b, word[23:8]};
            if (bc == 2'd3) begin
              bus.mem_we <= 1'b1;
              bus.mem_addr <= idx[ADDR_W-1:0];
              bus.mem_wdata <= {b, word};
              state <= WRITE;
            end
          end
          CKSUM: begin
            resp <= b == ck ? ACK : NAK;
            state <= RESP;
          end
          default: ;
        endcase
      if (state == WRITE) begin
        idx <= idx + 1'b1;
        state <= idx + 1'b1 == {1'b0, n} ? CKSUM : DATA;
      end
      if (state == RESP) begin
        if (!bus.uart_wr && !bus.uart_dout1[1]) begin
          bus.uart_addr <= 2'd0;
          bus.uart_wr <= 1'b1;
          bus.uart_din <= resp;
        end
        if (bus.uart_wr) begin
          bus.uart_addr <= 2'd1;
          state <= HUNT;
          cpu_rst <= cpu_rst && resp != ACK;
          boot_done <= boot_done || resp == ACK;
        end
      end
      // a stalled host aborts the frame; words already written stay in RAM
      if (timed_out) begin
        resp <= NAK;
        state <= RESP;
        ph <= 2'd0;
        bus.uart_rd <= 1'b0;
        bus.uart_addr <= 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames against a uart_fifo / program-RAM model with immediate-assert checks.
module tb_uart_boot_loader;
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic cpu_rst, boot_done;
  uart_boot_loader_if #(.DATA_W(8), .ADDR_W(12)) bus();
  uart_boot_loader #(.DATA_W(8), .ADDR_W(12), .TIMEOUT(100)) dut (
    .clk(clk), .rst_in(rst_in), .bus(bus), .cpu_rst(cpu_rst), .boot_done(boot_done)
  );
  always #5 clk = ~clk;
  logic [7:0]  rx_buf [256];
  logic [7:0]  tx_log [64];
  logic [11:0] mem_a [64];
  logic [31:0] mem_d [64];
  int wr_ptr = 0, rd_ptr = 0, tx_n = 0, tx_cyc = 0, mem_n = 0, cyc = 0;
  int compared = 0, mismatched = 0;
  logic tx_full = 1'b0, rd_viol = 1'b0, wr_viol = 1'b0;
  assign bus.uart_dout1 = {6'd0, tx_full, rd_ptr == wr_ptr};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.uart_rd) begin
      if (rd_ptr == wr_ptr) rd_viol <= 1'b1;
      else begin
        bus.uart_dout <= rx_buf[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
    if (bus.uart_wr) begin
      tx_log[tx_n[5:0]] <= bus.uart_din;
      tx_n <= tx_n + 1;
      tx_cyc <= cyc;
      if (tx_full) wr_viol <= 1'b1;
    end
    if (bus.mem_we) begin
      mem_a[mem_n[5:0]] <= bus.mem_addr;
      mem_d[mem_n[5:0]] <= bus.mem_wdata;
      mem_n <= mem_n + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] v);
    rx_buf[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask
  task automatic wait_tx(input int target, input string tag);
    int budget = 400;
    while (tx_n < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(tag, tx_n, target);
  endtask
  task automatic last_tx(input string tag, input logic [7:0] exp);
    int k = tx_n - 1;
    chk(tag, {24'd0, tx_log[k[5:0]]}, {24'd0, exp});
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_boot_done"}, boot_done, 0);
    chk({tag, "_uart_addr"}, bus.uart_addr, 1);
    chk({tag, "_uart_rd"}, bus.uart_rd, 0);
    chk({tag, "_uart_wr"}, bus.uart_wr, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_uart_din"}, bus.uart_din, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask
  initial begin
    int drop;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_in = 1'b1;
    // two-word frame, checksum bit0 flipped (good CK is 0x28)
    push(8'hA5); push(8'h02); push(8'h00);
    push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE); push(8'h29);
    wait_tx(1, "badck_tx_cnt");
    last_tx("badck_byte", 8'h15);
    chk("badck_writes", mem_n, 2);
    chk("badck_a0", mem_a[0], 0);
    chk("badck_d0", mem_d[0], 32'h12345678);
    chk("badck_a1", mem_a[1], 1);
    chk("badck_d1", mem_d[1], 32'hDEADBEEF);
    chk("badck_cpu_rst", cpu_rst, 1);
    chk("badck_boot_done", boot_done, 0);
    // same frame with the correct checksum
    push(8'hA5); push(8'h02); push(8'h00);
    push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE); push(8'h28);
    wait_tx(2, "good_tx_cnt");
    last_tx("good_byte", 8'h06);
    chk("good_writes", mem_n, 4);
    chk("good_a0", mem_a[2], 0);
    chk("good_d0", mem_d[2], 32'h12345678);
    chk("good_a1", mem_a[3], 1);
    chk("good_d1", mem_d[3], 32'hDEADBEEF);
    chk("good_cpu_rst", cpu_rst, 0);
    chk("good_boot_done", boot_done, 1);
    // garbage ahead of a one-word frame
    push(8'h00); push(8'hFF); push(8'h5A);
    push(8'hA5); push(8'h01); push(8'h00); push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h45);
    wait_tx(3, "garb_tx_cnt");
    last_tx("garb_byte", 8'h06);
    chk("garb_writes", mem_n, 5);
    chk("garb_a", mem_a[4], 0);
    chk("garb_d", mem_d[4], 32'h44332211);
    chk("garb_cpu_rst", cpu_rst, 0);
    // empty frame
    push(8'hA5); push(8'h00); push(8'h00); push(8'h00);
    wait_tx(4, "n0_tx_cnt");
    last_tx("n0_byte", 8'h06);
    chk("n0_writes", mem_n, 5);
    // N = 4097 is one word beyond capacity
    push(8'hA5); push(8'h01); push(8'h10);
    wait_tx(5, "big_tx_cnt");
    last_tx("big_byte", 8'h15);
    chk("big_writes", mem_n, 5);
    chk("big_cpu_rst", cpu_rst, 1);
    chk("big_boot_done", boot_done, 1);
    // stall after two data bytes
    push(8'hA5); push(8'h01); push(8'h00); push(8'h11); push(8'h22);
    repeat (60) @(negedge clk);
    chk("to_not_early", tx_n, 5);
    wait_tx(6, "to_tx_cnt");
    last_tx("to_byte", 8'h15);
    chk("to_writes", mem_n, 5);
    chk("to_cpu_rst", cpu_rst, 1);
    push(8'hA5); push(8'h01); push(8'h00); push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h45);
    wait_tx(7, "after_to_tx_cnt");
    last_tx("after_to_byte", 8'h06);
    chk("after_to_writes", mem_n, 6);
    chk("after_to_d", mem_d[5], 32'h44332211);
    chk("after_to_cpu_rst", cpu_rst, 0);
    // slow RX arrival with TX held full
    tx_full = 1'b1;
    push(8'hA5); repeat (20) @(negedge clk);
    push(8'h00); repeat (20) @(negedge clk);
    push(8'h00); repeat (20) @(negedge clk);
    push(8'h00);
    repeat (50) @(negedge clk);
    chk("txfull_hold", tx_n, 7);
    drop = cyc;
    tx_full = 1'b0;
    wait_tx(8, "slow_tx_cnt");
    chk("wr_latency", tx_cyc, drop + 1);
    last_tx("slow_byte", 8'h06);
    chk("rd_while_empty", rd_viol, 0);
    chk("wr_while_full", wr_viol, 0);
    // reset in the middle of DATA
    push(8'hA5); push(8'h01); push(8'h00); push(8'h11); push(8'h22);
    repeat (30) @(negedge clk);
    chk("mid_cpu_rst", cpu_rst, 1);
    rst_in = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    rst_in = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid_no_write", mem_n, 6);
    chk("mid_rd_viol", rd_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
